// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage and the IF/ID pipeline register.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_INSTR_W = 32;

  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR        = FETCH_INSTR_W'(0);
  localparam logic [FETCH_ADDR_W-1:0]  PC_RESET_DEFAULT = FETCH_ADDR_W'(0);

  // IF/ID payload, also consumed by the ID stage
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
    logic                     valid;
  } if_id_t;

  function automatic logic [FETCH_ADDR_W-1:0] word_align(input logic [FETCH_ADDR_W-1:0] a);
    return {a[FETCH_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous reset, load-enable, next-value input.
module pc_reg #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT),
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_load;
  if_id_t            if_id_q;
  if_id_t            if_id_d;
  logic              do_fetch;

  assign pc_seq   = pc_q + ADDR_W'(PC_STEP);
  assign do_fetch = !branch_taken && !freeze;

  // Priority mux: branch redirect over freeze over sequential fetch
  always_comb begin
    pc_d    = pc_seq;
    pc_load = 1'b0;
    if_id_d = if_id_q;
    if (branch_taken) begin
      pc_d          = {branch_addr[ADDR_W-1:2], 2'b00};
      pc_load       = 1'b1;
      if_id_d.pc    = FETCH_ADDR_W'(0);
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (!freeze) begin
      pc_load       = 1'b1;
      if_id_d.pc    = FETCH_ADDR_W'(pc_seq);
      if_id_d.instr = FETCH_INSTR_W'(imem_instr);
      if_id_d.valid = 1'b1;
    end
  end

  pc_reg #(
    .ADDR_W    (ADDR_W),
    .RESET_VAL (PC_RESET)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q.pc    <= FETCH_ADDR_W'(0);
      if_id_q.instr <= NOP_INSTR;
      if_id_q.valid <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = ADDR_W'(if_id_q.pc);
  assign if_id_instr = INSTR_W'(if_id_q.instr);
  assign if_id_valid = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  // Fetch and stall counters; flushes do not clear them
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (do_fetch) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (freeze && !branch_taken) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_do_fetch;
  assign unused_do_fetch = do_fetch;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors, literal checks and a per-cycle model compare.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Memory returns the word index of the address
  assign imem_instr = imem_addr >> 2;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of the architectural state
  logic [31:0] m_pc, m_ipc, m_instr, m_fetch, m_stall;
  logic        m_valid;
  bit          m_known = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_fetch = 0; m_stall = 0; m_known = 1;
    end else if (branch_taken) begin
      m_pc = branch_addr & ~32'h3; m_ipc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (freeze) begin
      m_stall = m_stall + 1;
    end else begin
      m_instr = m_pc / 4;
      m_pc    = m_pc + 4;
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_fetch = m_fetch + 1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model imem_addr", imem_addr, m_pc);
      chk("model if_id_pc", if_id_pc, m_ipc);
      chk("model if_id_instr", if_id_instr, m_instr);
      chk("model if_id_valid", 32'(if_id_valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
      chk("model perf_fetch", perf_fetch_cnt, m_fetch);
      chk("model perf_stall", perf_stall_cnt, m_stall);
`endif
    end
  end

  task automatic cycle(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                              input logic [31:0] ins, input logic v);
    chk({tag, " imem_addr"}, imem_addr, pc);
    chk({tag, " if_id_pc"}, if_id_pc, ipc);
    chk({tag, " if_id_instr"}, if_id_instr, ins);
    chk({tag, " if_id_valid"}, 32'(if_id_valid), 32'(v));
  endtask

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0);
    expect_state("reset", 32'h0, 32'h0, 32'h0, 0);

    // Four free-running edges
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 0);
      expect_state("seq", 32'(4 * i), 32'(4 * i), 32'(i - 1), 1);
    end

    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    expect_state("pre_freeze", 32'h8, 32'h8, 32'h1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      expect_state("freeze", 32'h8, 32'h8, 32'h1, 1);
    end
    cycle(0, 0, 0, 0);
    expect_state("release", 32'hC, 32'hC, 32'h2, 1);

    cycle(0, 0, 1, 32'h40);
    expect_state("branch", 32'h40, 32'h0, 32'h0, 0);
    cycle(0, 0, 0, 0);
    expect_state("target", 32'h44, 32'h44, 32'h10, 1);

    cycle(0, 1, 1, 32'h23);
    expect_state("br_frz", 32'h20, 32'h0, 32'h0, 0);
    cycle(0, 0, 0, 0);
    expect_state("br_frz_next", 32'h24, 32'h24, 32'h8, 1);

    cycle(0, 0, 1, 32'hFFFF_FFFF);
    expect_state("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
    cycle(0, 0, 0, 0);
    expect_state("wrap", 32'h0, 32'h0, 32'h3FFF_FFFF, 1);

    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    expect_state("rst_frz", 32'h0, 32'h0, 32'h0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 32'h80);
    expect_state("rst_br", 32'h0, 32'h0, 32'h0, 0);

`ifdef FETCH_PERF_CNT_EN
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    chk("perf_fetch=5", perf_fetch_cnt, 32'd5);
    chk("perf_stall=3", perf_stall_cnt, 32'd3);
    cycle(1, 0, 0, 0);
    chk("perf_fetch rst", perf_fetch_cnt, 32'd0);
    chk("perf_stall rst", perf_stall_cnt, 32'd0);
`endif

    // Pseudo-random mix checked by the model only
    for (int i = 0; i < 60; i++) begin
      cycle(0, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 6) == 0), $urandom);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
